// File: rtl/branch_resolver_if.sv
// Execute-to-fetch bus for branch_resolver: instruction fields and ALU flags in, resolved redirect out.
// Carries misalign only when BRANCH_MISALIGN_EN is defined.
interface branch_resolver_if #(
  parameter int XLEN = 64
);
  logic            valid_in;
  logic            ready_in;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            EQ;
  logic            GT_SN;
  logic            LT_SN;
  logic            GT_UN;
  logic            LT_UN;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1;
  logic            valid_out;
  logic            ready_out;
  logic            taken;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] link;
  logic            flush;
`ifdef BRANCH_MISALIGN_EN
  logic            misalign;
`endif

  modport master (
`ifdef BRANCH_MISALIGN_EN
    input  misalign,
`endif
    output valid_in, opcode, funct3, EQ, GT_SN, LT_SN, GT_UN, LT_UN,
    output pc, imm, rs1, ready_out,
    input  ready_in, valid_out, taken, target, link, flush
  );

  modport slave (
`ifdef BRANCH_MISALIGN_EN
    output misalign,
`endif
    input  valid_in, opcode, funct3, EQ, GT_SN, LT_SN, GT_UN, LT_UN,
    input  pc, imm, rs1, ready_out,
    output ready_in, valid_out, taken, target, link, flush
  );
endinterface

// File: rtl/branch_resolver.sv
// Resolves branch/JAL/JALR from ALU flags, registers the redirect behind valid/ready, then holds flush.
// Optional BRANCH_MISALIGN_EN: flags taken targets with bit 1 set and suppresses their flush.
//
// state | meaning
// IDLE  | ready for a new instruction
// HOLD  | result registered, waiting for ready_out
// FLUSH | taken transfer accepted, flush held until counter terminal count
module branch_resolver #(
  parameter int XLEN         = 64,
  parameter int FLUSH_CYCLES = 2
) (
  input logic              clk,
  input logic              rst_n,
  branch_resolver_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  logic [1:0]      state;
  logic [3:0]      flush_cnt;
  logic            dec_taken;
  logic [XLEN-1:0] dec_target;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jalr_sum;
  logic            go_flush;
  logic            unused_flags;

  // Greater-than flags are not needed: every condition is an EQ or LT test or its inverse.
  assign unused_flags = bus.GT_SN ^ bus.GT_UN;

  always_comb begin
    pc_plus4   = bus.pc + XLEN'(4);
    br_target  = bus.pc + bus.imm;
    jalr_sum   = bus.rs1 + bus.imm;
    dec_taken  = 1'b0;
    dec_target = pc_plus4;
    case (bus.opcode)
      OP_BRANCH: begin
        case (bus.funct3)
          3'b000:  dec_taken = bus.EQ;
          3'b001:  dec_taken = ~bus.EQ;
          3'b100:  dec_taken = bus.LT_SN;
          3'b101:  dec_taken = ~bus.LT_SN;
          3'b110:  dec_taken = bus.LT_UN;
          3'b111:  dec_taken = ~bus.LT_UN;
          default: dec_taken = 1'b0;
        endcase
        if (dec_taken) dec_target = br_target;
      end
      OP_JAL: begin
        dec_taken  = 1'b1;
        dec_target = br_target;
      end
      OP_JALR: begin
        dec_taken  = 1'b1;
        dec_target = {jalr_sum[XLEN-1:1], 1'b0};
      end
      default: begin
        dec_taken  = 1'b0;
        dec_target = pc_plus4;
      end
    endcase
  end

`ifdef BRANCH_MISALIGN_EN
  // A misaligned transfer is redirected by the exception path, so no flush here.
  assign go_flush = bus.taken & ~bus.misalign;
`else
  assign go_flush = bus.taken;
`endif

  assign bus.ready_in = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      flush_cnt     <= 4'd0;
      bus.valid_out <= 1'b0;
      bus.taken     <= 1'b0;
      bus.target    <= '0;
      bus.link      <= '0;
      bus.flush     <= 1'b0;
`ifdef BRANCH_MISALIGN_EN
      bus.misalign  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.valid_in) begin
            bus.taken     <= dec_taken;
            bus.target    <= dec_target;
            bus.link      <= pc_plus4;
            bus.valid_out <= 1'b1;
`ifdef BRANCH_MISALIGN_EN
            bus.misalign  <= dec_taken & dec_target[1];
`endif
            state         <= HOLD;
          end
        end
        HOLD: begin
          if (bus.ready_out) begin
            bus.valid_out <= 1'b0;
            if (go_flush) begin
              flush_cnt <= FLUSH_LOAD;
              bus.flush <= 1'b1;
              state     <= FLUSH;
            end else begin
              state <= IDLE;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == 4'd1) begin
            flush_cnt <= 4'd0;
            bus.flush <= 1'b0;
            state     <= IDLE;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: begin
          state     <= IDLE;
          bus.flush <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Consumes the comparison flags the ALU produces (EQ, GT_SN, LT_SN, GT_UN, LT_UN) together with the instruction fields, and decides whether a control transfer is taken.
- Computes the redirect target and the link address.
- Registers the result behind a valid/ready handshake, then drives a timed pipeline flush on taken transfers.
- Sits between the execute stage and the fetch/PC logic.

Parameters:
- XLEN, 64, width of PC, immediate, rs1 and target datapaths.
- FLUSH_CYCLES, 2, number of cycles flush is held high after a taken transfer is accepted (legal 1..15).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- valid_in  input  1  instruction fields and flags are valid
- ready_in  output  1  block can accept a new instruction
- opcode  input  7  instruction opcode
- funct3  input  3  branch condition select
- EQ  input  1  ALU equal flag
- GT_SN  input  1  ALU signed greater-than flag (not used by any condition; ignored)
- LT_SN  input  1  ALU signed less-than flag
- GT_UN  input  1  ALU unsigned greater-than flag (not used by any condition; ignored)
- LT_UN  input  1  ALU unsigned less-than flag
- pc  input  XLEN  PC of the instruction
- imm  input  XLEN  sign-extended immediate
- rs1  input  XLEN  rs1 value, used by JALR
- valid_out  output  1  result registers valid
- ready_out  input  1  downstream accepts the result
- taken  output  1  registered taken decision
- target  output  XLEN  registered next PC
- link  output  XLEN  registered pc+4
- flush  output  1  pipeline flush request

Behaviour:
- Clock and reset: single clock, clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE; valid_out=0, taken=0, target=0, link=0, flush=0; flush counter=0. ready_in=1 (it is combinational, derived from state).
- Decision, combinational from the inputs and captured on accept:
  - opcode 1100011 (branch), condition by funct3:
    - 000 -> EQ
    - 001 -> ~EQ
    - 100 -> LT_SN
    - 101 -> ~LT_SN
    - 110 -> LT_UN
    - 111 -> ~LT_UN
    - 010/011 -> not taken
  - Branch taken target = pc+imm.
  - opcode 1101111 (JAL): always taken; target = pc+imm.
  - opcode 1100111 (JALR): always taken; target = (rs1+imm) with bit 0 cleared.
  - Any other opcode: taken=0.
  - Whenever taken=0, target = pc+4.
  - link = pc+4 for every accepted instruction.
- Arithmetic: all sums are modulo 2^XLEN; wrap-around is silent.
- States:
  - IDLE: ready_in=1. On valid_in=1, capture the decision; next state HOLD, valid_out=1 next cycle.
  - HOLD: ready_in=0; valid_out=1; outputs stable. On ready_out=1:
    - taken=1 -> FLUSH; load counter with FLUSH_CYCLES; flush=1 from the next cycle.
    - taken=0 -> IDLE; valid_out=0.
  - FLUSH: ready_in=0; valid_out=0; flush=1. Counter decrements each cycle. When counter reaches 1, next state is IDLE and flush deasserts on that edge. flush is therefore high for exactly FLUSH_CYCLES cycles.
- Latency and throughput:
  - Accept to valid_out: 1 cycle.
  - Not-taken throughput: one instruction per 2 cycles when ready_out is held high.
- Simultaneous events:
  - valid_in is ignored outside IDLE; upstream must hold valid_in until it sees ready_in.
  - ready_out is ignored outside HOLD.
- Reset asserted mid-operation (in HOLD or FLUSH): immediately returns to reset values; any in-flight result and any pending flush are discarded.

Optional Feature:
- Macro: BRANCH_MISALIGN_EN.
- When defined:
  - Adds output misalign (1 bit, reset 0).
  - On accept, misalign is registered to 1 if taken=1 and target bit 1 is 1 (IALIGN=32). Its valid_out qualification is the same as taken's.
  - A misaligned transfer goes HOLD -> IDLE on ready_out=1 with flush=0; the exception path performs the redirect.
- When undefined: the misalign port is absent; misaligned targets are treated as ordinary taken transfers.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> ready_in=1, valid_out=0, flush=0, taken=0, target=0.
- BEQ taken: opcode=1100011, funct3=000, EQ=1, pc=0x1000, imm=0x20, ready_out=1 -> next cycle valid_out=1, taken=1, target=0x1020, link=0x1004. Then flush=1 for exactly 2 cycles with ready_in=0; then ready_in=1.
- BLTU not taken with backpressure: funct3=110, LT_UN=0, pc=0x2000; ready_out low for 3 cycles -> valid_out and target=0x2004 held stable, taken=0. On ready_out=1 -> IDLE next cycle, flush never asserts.
- JALR: opcode=1100111, rs1=0x3001, imm=0x10 -> taken=1, target=0x3010, link=pc+4.
- Wrap-around: pc=0xFFFF_FFFF_FFFF_FFFC, BNE with EQ=0, imm=0x8 -> target=0x4; link=0x0.
- Reset mid-FLUSH: assert rst_n=0 during the first flush cycle -> flush=0 immediately (asynchronous), valid_out=0. After release, ready_in=1.
- BRANCH_MISALIGN_EN defined: JAL with pc=0x1000, imm=0x2 -> taken=1, misalign=1, no flush after handshake.
